// File: rtl/alu_decode_stage_pkg.sv
// ============================================================================
// Module   : alu_decode_stage_pkg
// Brief    : RV32I opcode/funct constants and ALU one-hot control bit indices,
//            shared by the decode stage and the ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_decode_stage_pkg;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_srl_sra = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    // Bit positions inside the one-hot ALU control word
    localparam int c_alu_add  = 0;
    localparam int c_alu_sub  = 1;
    localparam int c_alu_slt  = 2;
    localparam int c_alu_sltu = 3;
    localparam int c_alu_and  = 4;
    localparam int c_alu_or   = 5;
    localparam int c_alu_xor  = 6;
    localparam int c_alu_sll  = 7;
    localparam int c_alu_srl  = 8;
    localparam int c_alu_sra  = 9;
    localparam int c_alu_lui  = 10;
    localparam int c_alu_op_w = 11;

    typedef logic [c_alu_op_w-1:0] alu_op_t;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

    function automatic alu_op_t alu_onehot(input int unsigned idx);
        alu_op_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
// Module   : alu_op_decoder
// Brief    : Combinational RV32I ALU-class decoder: one-hot op, operand
//            selects, immediate, register fields and illegal flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    output alu_op_t     alu_op,
    output src1_sel_e   src1_sel,
    output src2_sel_e   src2_sel,
    output logic [31:0] imm,
    output logic        illegal,
    output logic        rf_we,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    alu_op_t    w_op;
    logic       w_illegal;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign rd       = inst[11:7];

    always_comb begin
        w_op      = '0;
        w_illegal = 1'b0;
        src1_sel  = SRC1_RS1;
        src2_sel  = SRC2_RS2;
        imm       = {{20{inst[31]}}, inst[31:20]};
        case (w_opcode)
            c_opc_op: begin
                if (w_f7 == c_f7_base) begin
                    case (w_f3)
                        c_f3_add_sub: w_op = alu_onehot(c_alu_add);
                        c_f3_sll:     w_op = alu_onehot(c_alu_sll);
                        c_f3_slt:     w_op = alu_onehot(c_alu_slt);
                        c_f3_sltu:    w_op = alu_onehot(c_alu_sltu);
                        c_f3_xor:     w_op = alu_onehot(c_alu_xor);
                        c_f3_srl_sra: w_op = alu_onehot(c_alu_srl);
                        c_f3_or:      w_op = alu_onehot(c_alu_or);
                        default:      w_op = alu_onehot(c_alu_and);
                    endcase
                end else if (w_f7 == c_f7_alt && w_f3 == c_f3_add_sub) begin
                    w_op = alu_onehot(c_alu_sub);
                end else if (w_f7 == c_f7_alt && w_f3 == c_f3_srl_sra) begin
                    w_op = alu_onehot(c_alu_sra);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_opc_op_imm: begin
                src2_sel = SRC2_IMM;
                case (w_f3)
                    c_f3_add_sub: w_op = alu_onehot(c_alu_add);
                    c_f3_slt:     w_op = alu_onehot(c_alu_slt);
                    c_f3_sltu:    w_op = alu_onehot(c_alu_sltu);
                    c_f3_xor:     w_op = alu_onehot(c_alu_xor);
                    c_f3_or:      w_op = alu_onehot(c_alu_or);
                    c_f3_and:     w_op = alu_onehot(c_alu_and);
                    c_f3_sll: begin
                        imm = {27'b0, inst[24:20]};
                        if (w_f7 == c_f7_base) w_op = alu_onehot(c_alu_sll);
                        else                   w_illegal = 1'b1;
                    end
                    default: begin
                        imm = {27'b0, inst[24:20]};
                        if (w_f7 == c_f7_base)     w_op = alu_onehot(c_alu_srl);
                        else if (w_f7 == c_f7_alt) w_op = alu_onehot(c_alu_sra);
                        else                       w_illegal = 1'b1;
                    end
                endcase
            end
            c_opc_lui: begin
                w_op     = alu_onehot(c_alu_lui);
                src1_sel = SRC1_ZERO;
                src2_sel = SRC2_IMM;
                imm      = {inst[31:12], 12'b0};
            end
            c_opc_auipc: begin
                w_op     = alu_onehot(c_alu_add);
                src1_sel = SRC1_PC;
                src2_sel = SRC2_IMM;
                imm      = {inst[31:12], 12'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal encodings never carry an op, so the one-hot word is all-zero
    assign alu_op  = w_illegal ? '0 : w_op;
    assign illegal = w_illegal;
    assign rf_we   = ~w_illegal & (inst[11:7] != 5'd0);

endmodule

`default_nettype wire

// File: rtl/alu_decode_stage.sv
// ============================================================================
// Module   : alu_decode_stage
// Brief    : RV32I ALU decode stage: register-file read, operand selection and
//            a single valid/ready pipeline register toward execute.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 11
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic [4:0]          rf_raddr1,
    output logic [4:0]          rf_raddr2,
    input  logic [XLEN-1:0]     rf_rdata1,
    input  logic [XLEN-1:0]     rf_rdata2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [XLEN-1:0]     out_alu_src1,
    output logic [XLEN-1:0]     out_alu_src2,
    output logic [4:0]          out_rd,
    output logic                out_rf_we,
    output logic [XLEN-1:0]     out_pc,
    output logic                out_illegal
);

    alu_op_t        w_alu_op;
    src1_sel_e      w_src1_sel;
    src2_sel_e      w_src2_sel;
    logic [31:0]    w_imm;
    logic           w_illegal;
    logic           w_rf_we;
    logic [4:0]     w_rd;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;
    logic           w_accept;

    logic                r_valid;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic [XLEN-1:0]     r_src1;
    logic [XLEN-1:0]     r_src2;
    logic [4:0]          r_rd;
    logic                r_rf_we;
    logic [XLEN-1:0]     r_pc;
    logic                r_illegal;

    alu_op_decoder u_dec (
        .inst     (in_inst),
        .alu_op   (w_alu_op),
        .src1_sel (w_src1_sel),
        .src2_sel (w_src2_sel),
        .imm      (w_imm),
        .illegal  (w_illegal),
        .rf_we    (w_rf_we),
        .rs1      (rf_raddr1),
        .rs2      (rf_raddr2),
        .rd       (w_rd)
    );

    always_comb begin
        w_src1 = '0;
        case (w_src1_sel)
            SRC1_RS1: w_src1 = rf_rdata1;
            SRC1_PC:  w_src1 = in_pc;
            default:  w_src1 = '0;
        endcase
    end

    assign w_src2   = (w_src2_sel == SRC2_IMM) ? w_imm : rf_rdata2;
    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_rd      <= '0;
            r_rf_we   <= 1'b0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else begin
            // Flush beats a simultaneous accept
            if (flush)          r_valid <= 1'b0;
            else if (w_accept)  r_valid <= 1'b1;
            else if (out_ready) r_valid <= 1'b0;

            if (w_accept && !flush) begin
                r_alu_op  <= w_alu_op;
                r_src1    <= w_src1;
                r_src2    <= w_src2;
                r_rd      <= w_rd;
                r_rf_we   <= w_rf_we;
                r_pc      <= in_pc;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_alu_op   = r_alu_op;
    assign out_alu_src1 = r_src1;
    assign out_alu_src2 = r_src2;
    assign out_rd       = r_rd;
    assign out_rf_we    = r_rf_we;
    assign out_pc       = r_pc;
    assign out_illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
// ============================================================================
// Module   : tb_alu_decode_stage
// Brief    : Directed vector bench for alu_decode_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_decode_stage;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_alu_op;
    logic [31:0] out_alu_src1;
    logic [31:0] out_alu_src2;
    logic [4:0]  out_rd;
    logic        out_rf_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_decode_stage #(.XLEN(32), .ALU_OP_W(11)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_op   (out_alu_op),
        .out_alu_src1 (out_alu_src1),
        .out_alu_src2 (out_alu_src2),
        .out_rd       (out_rd),
        .out_rf_we    (out_rf_we),
        .out_pc       (out_pc),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [10:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        chk_src;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic add(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [10:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] rd, input logic we,
                       input logic ill, input logic chk_src);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.op = op;
        v.s1 = s1; v.s2 = s2; v.rd = rd; v.we = we; v.ill = ill; v.chk_src = chk_src;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_inst   = v.inst;
        in_pc     = v.pc;
        rf_rdata1 = v.rd1;
        rf_rdata2 = v.rd2;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;

        //   inst                                pc          rd1          rd2          op      s1           s2           rd  we ill chk
        add(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h100, 32'd5,       32'd7,       11'h001, 32'd5,       32'd7,       3,  1, 0, 1);
        add(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5), 32'h104, 32'd10,      32'd3,       11'h002, 32'd10,      32'd3,       5,  1, 0, 1);
        add(enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd1), 32'h108, 32'hA,       32'hB,       11'h004, 32'hA,       32'hB,       1,  1, 0, 1);
        add(enc_r(7'h00, 5'd3, 5'd2, 3'd3, 5'd1), 32'h10C, 32'hC,       32'hD,       11'h008, 32'hC,       32'hD,       1,  1, 0, 1);
        add(enc_r(7'h00, 5'd9, 5'd8, 3'd7, 5'd7), 32'h110, 32'hF0F0,    32'h0FF0,    11'h010, 32'hF0F0,    32'h0FF0,    7,  1, 0, 1);
        add(enc_r(7'h00, 5'd9, 5'd8, 3'd6, 5'd7), 32'h114, 32'h1,       32'h2,       11'h020, 32'h1,       32'h2,       7,  1, 0, 1);
        add(enc_r(7'h00, 5'd9, 5'd8, 3'd4, 5'd7), 32'h118, 32'h3,       32'h4,       11'h040, 32'h3,       32'h4,       7,  1, 0, 1);
        add(enc_r(7'h00, 5'd9, 5'd8, 3'd1, 5'd7), 32'h11C, 32'h5,       32'h6,       11'h080, 32'h5,       32'h6,       7,  1, 0, 1);
        add(enc_r(7'h00, 5'd9, 5'd8, 3'd5, 5'd7), 32'h120, 32'h7,       32'h8,       11'h100, 32'h7,       32'h8,       7,  1, 0, 1);
        add(enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd7), 32'h124, 32'h9,       32'h1F,      11'h200, 32'h9,       32'h1F,      7,  1, 0, 1);
        add(32'h4032D213,                         32'h128, 32'h80000000,32'h55,      11'h200, 32'h80000000,32'd3,       4,  1, 0, 1);
        add(enc_i(12'hFFF, 5'd1, 3'd0, 5'd2),     32'h12C, 32'h11,      32'h99,      11'h001, 32'h11,      32'hFFFFFFFF,2,  1, 0, 1);
        add(enc_i(12'h800, 5'd7, 3'd2, 5'd6),     32'h130, 32'h12,      32'h99,      11'h004, 32'h12,      32'hFFFFF800,6,  1, 0, 1);
        add(enc_i(12'h7FF, 5'd7, 3'd3, 5'd6),     32'h134, 32'h13,      32'h99,      11'h008, 32'h13,      32'h000007FF,6,  1, 0, 1);
        add(enc_i(12'h0F0, 5'd7, 3'd4, 5'd6),     32'h138, 32'h14,      32'h99,      11'h040, 32'h14,      32'h000000F0,6,  1, 0, 1);
        add(enc_i(12'h00F, 5'd7, 3'd6, 5'd6),     32'h13C, 32'h15,      32'h99,      11'h020, 32'h15,      32'h0000000F,6,  1, 0, 1);
        add(enc_i(12'h0FF, 5'd7, 3'd7, 5'd6),     32'h140, 32'h16,      32'h99,      11'h010, 32'h16,      32'h000000FF,6,  1, 0, 1);
        add(enc_i(12'h01F, 5'd9, 3'd1, 5'd9),     32'h144, 32'h17,      32'h99,      11'h080, 32'h17,      32'd31,      9,  1, 0, 1);
        add(enc_i(12'h001, 5'd9, 3'd5, 5'd9),     32'h148, 32'h18,      32'h99,      11'h100, 32'h18,      32'd1,       9,  1, 0, 1);
        add(32'h12345097,                         32'h1000,32'h77,      32'h88,      11'h001, 32'h1000,    32'h12345000,1,  1, 0, 1);
        add(32'h00001037,                         32'h1004,32'h77,      32'h88,      11'h400, 32'h0,       32'h00001000,0,  0, 0, 1);
        add(32'hFFFFFFB7,                         32'h1008,32'h77,      32'h88,      11'h400, 32'h0,       32'hFFFFF000,31, 1, 0, 1);
        add(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h100C,32'd1,       32'd2,       11'h001, 32'd1,       32'd2,       0,  0, 0, 1);
        add(32'h0000006F,                         32'h1010,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       0,  0, 1, 0);
        add(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4), 32'h1014,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       4,  0, 1, 0);
        add(enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd4), 32'h1018,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       4,  0, 1, 0);
        add(enc_i(12'h402, 5'd1, 3'd1, 5'd8),     32'h101C,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       8,  0, 1, 0);
        add(enc_i(12'h022, 5'd1, 3'd5, 5'd8),     32'h1020,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       8,  0, 1, 0);
        add(32'h00000000,                         32'h1024,32'h0,       32'h0,       11'h000, 32'h0,       32'h0,       0,  0, 1, 0);

        // Reset state, before any clock edge
        #3;
        chk("reset out_valid",   32'(out_valid),   32'h0);
        chk("reset out_alu_op",  32'(out_alu_op),  32'h0);
        chk("reset out_src1",    out_alu_src1,     32'h0);
        chk("reset out_src2",    out_alu_src2,     32'h0);
        chk("reset out_pc",      out_pc,           32'h0);
        chk("reset out_rf_we",   32'(out_rf_we),   32'h0);
        chk("reset out_illegal", 32'(out_illegal), 32'h0);
        chk("reset in_ready",    32'(in_ready),    32'h1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Back-to-back table with out_ready held high
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d rf_raddr1", i), 32'(rf_raddr1), 32'(vecs[i].inst[19:15]));
            chk($sformatf("v%0d rf_raddr2", i), 32'(rf_raddr2), 32'(vecs[i].inst[24:20]));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid),   32'h1);
            chk($sformatf("v%0d alu_op", i),    32'(out_alu_op),  32'(vecs[i].op));
            chk($sformatf("v%0d onehot", i),    32'($countones(out_alu_op)), vecs[i].ill ? 32'd0 : 32'd1);
            chk($sformatf("v%0d rd", i),        32'(out_rd),      32'(vecs[i].rd));
            chk($sformatf("v%0d rf_we", i),     32'(out_rf_we),   32'(vecs[i].we));
            chk($sformatf("v%0d illegal", i),   32'(out_illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d pc", i),        out_pc,           vecs[i].pc);
            if (vecs[i].chk_src) begin
                chk($sformatf("v%0d src1", i), out_alu_src1, vecs[i].s1);
                chk($sformatf("v%0d src2", i), out_alu_src2, vecs[i].s2);
            end
        end

        // Stall: hold ADD for three cycles while SUB waits upstream
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(vecs[1]);
        out_ready = 1'b0;
        #1;
        chk("stall in_ready", 32'(in_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d out_valid", c), 32'(out_valid),  32'h1);
            chk($sformatf("stall%0d alu_op", c),    32'(out_alu_op), 32'h001);
            chk($sformatf("stall%0d src1", c),      out_alu_src1,    32'd5);
            chk($sformatf("stall%0d src2", c),      out_alu_src2,    32'd7);
            chk($sformatf("stall%0d rd", c),        32'(out_rd),     32'd3);
            chk($sformatf("stall%0d in_ready", c),  32'(in_ready),   32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("b2b out_valid", 32'(out_valid),  32'h1);
        chk("b2b alu_op",    32'(out_alu_op), 32'h002);
        chk("b2b src1",      out_alu_src1,    32'd10);
        chk("b2b rd",        32'(out_rd),     32'd5);

        // Flush with an incoming instruction that would otherwise transfer
        @(negedge clk);
        drive(vecs[2]);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-flush out_valid", 32'(out_valid), 32'h0);

        // Flush while stalled drops the held instruction
        @(negedge clk);
        drive(vecs[3]);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("stall-flush out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset while stalled
        @(negedge clk);
        drive(vecs[19]);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'h1);
        chk("pre-reset out_pc",    out_pc,         32'h1000);
        in_valid = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        chk("async reset out_valid",  32'(out_valid),  32'h0);
        chk("async reset out_alu_op", 32'(out_alu_op), 32'h0);
        chk("async reset out_src1",   out_alu_src1,    32'h0);
        chk("async reset out_src2",   out_alu_src2,    32'h0);
        chk("async reset out_rd",     32'(out_rd),     32'h0);
        chk("async reset out_rf_we",  32'(out_rf_we),  32'h0);
        chk("async reset out_pc",     out_pc,          32'h0);
        @(negedge clk);
        resetn = 1'b1;
        drive(vecs[20]);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("after reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("after reset out_valid", 32'(out_valid),  32'h1);
        chk("after reset alu_op",    32'(out_alu_op), 32'h400);
        chk("after reset rf_we",     32'(out_rf_we),  32'h0);

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
